// File: rtl/div_pkg.sv
// Shared types and constants for the iterative MIPS divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ZERO,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

    localparam int          DIV_WIDTH    = 32;
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] sh_rem;
    logic [WIDTH:0] diff;

    // Shifted remainder needs one extra bit: it can reach 2*dvsr-1.
    always_comb begin
        sh_rem = {rem_i, quo_i[WIDTH-1]};
        diff   = sh_rem - {1'b0, dvsr_i};
        if (sh_rem >= {1'b0, dvsr_i}) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = sh_rem[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: stalls the pipeline while running, then writes
// remainder/quotient to HI/LO on a one-cycle completion pulse.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             annul,
    output logic             busy_o,
    output logic             ready_o,
    output logic [1:0]       hilo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             accept, zero_div;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    assign accept   = start && !annul;
    assign zero_div = (opdata2 == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    // Divide-by-zero keeps the raw dividend and skips sign fix-up.
                    neg_quo_d = signed_div && !zero_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_rem_d = signed_div && !zero_div && opdata1[WIDTH-1];
                    quo_d     = (signed_div && !zero_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
                    dvsr_d    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = zero_div ? DIV_ZERO : DIV_RUN;
                end
            end
            DIV_ZERO: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    // Park in RUN with a full counter so the result lands on the common DONE path.
                    rem_d   = quo_q;
                    quo_d   = '1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    hi_d    = neg_rem_q ? -rem_q : rem_q;
                    lo_d    = neg_quo_q ? -quo_q : quo_q;
                    state_d = DIV_DONE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o  = ((state_q == DIV_IDLE) && accept) || (state_q == DIV_ZERO) || (state_q == DIV_RUN);
    assign ready_o = (state_q == DIV_DONE) && !annul;
    assign hilo_we = {2{ready_o}};
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed checks of div_unit: results, latency, stall, annul and reset behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        annul = 1'b0;
    logic        busy_o, ready_o;
    logic [1:0]  hilo_we;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .hilo_we    (hilo_we),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo);
        int   lat;
        logic busy_ok;
        start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
        #1 chk({tag, " busy_at_start"}, 32'(busy_o), 32'd1);
        @(posedge clk); @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!ready_o && lat < 40) begin
            if (!busy_o) busy_ok = 1'b0;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
        chk({tag, " hilo_we"}, 32'(hilo_we), 32'd3);
        chk({tag, " busy_in_done"}, 32'(busy_o), 32'd0);
        chk({tag, " hi"}, hi_o, ehi);
        chk({tag, " lo"}, lo_o, elo);
        @(posedge clk); @(negedge clk);
        chk({tag, " ready_after_done"}, 32'(ready_o), 32'd0);
        chk({tag, " hi_hold"}, hi_o, ehi);
        chk({tag, " lo_hold"}, lo_o, elo);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset ready", 32'(ready_o), 32'd0);
        chk("reset hilo_we", 32'(hilo_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: each start lands in the IDLE cycle right after DONE.
        run_op("divu_100_7",   1'b0, 32'd100,        32'd7,        33, 32'd2,        32'd14);
        run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE, 33, 32'd1,        32'hFFFF_FFFD);
        run_op("div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'd0,        32'h8000_0000);
        run_op("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,        33, 32'd0,        32'hFFFF_FFFF);
        run_op("div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 33, 32'hFFFF_FFFE, 32'd14);
        run_op("divu_5_9",     1'b0, 32'd5,          32'd9,        33, 32'd5,        32'd0);
        run_op("divu_1234_0",  1'b0, 32'd1234,       32'd0,        2,  32'd1234,     32'hFFFF_FFFF);

        // Annul at RUN step 10: no write, previous result (1234 / all-ones) kept.
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        annul = 1'b1;
        @(posedge clk); @(negedge clk);
        annul = 1'b0;
        chk("annul busy", 32'(busy_o), 32'd0);
        chk("annul ready", 32'(ready_o), 32'd0);
        chk("annul hi_kept", hi_o, 32'd1234);
        chk("annul lo_kept", lo_o, 32'hFFFF_FFFF);
        @(negedge clk);
        run_op("after_annul", 1'b0, 32'd1000, 32'd3, 33, 32'd1, 32'd333);

        // Reset mid-RUN with start held high.
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst hi", hi_o, 32'd0);
        chk("rst lo", lo_o, 32'd0);
        chk("rst ready", 32'(ready_o), 32'd0);
        chk("rst hilo_we", 32'(hilo_we), 32'd0);
        rst = 1'b0;
        run_op("after_rst", 1'b0, 32'd50, 32'd5, 33, 32'd0, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
